// File: rtl/sync_arb_pkg.sv
// ============================================================================
// Module      : sync_arb_pkg
// Description : Shared types and sizing helpers for the synchronizer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter loads HOLD-1 / GAP-1, so clog2 of the larger value suffices.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_arb_picker.sv
// ============================================================================
// Module      : sync_arb_picker
// Description : Combinational winner selection. Round-robin starting after
//               the pointer when SYNC_ARB_RR_EN is defined, else fixed
//               priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_arb_picker
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifdef SYNC_ARB_RR_EN
    input  logic [IDX_W-1:0]   ptr_i,
`endif
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

`ifdef SYNC_ARB_RR_EN
    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[c]) begin
                found = 1'b1;
                idx_o = IDX_W'(c);
            end
        end
    end
`else
    always_comb begin
        idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_o = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        any_o    = |req_i;
        onehot_o = '0;
        if (any_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_sync_arbiter.sv
// ============================================================================
// Module      : data_sync_arbiter
// Description : Shares one bus-synchronizer channel among NUM_REQ requesters:
//               grant, hold data/enable HOLD_CYCLES, then force an enable-low
//               gap. Macro SYNC_ARB_RR_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sync_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 5,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [idx_width(NUM_REQ)-1:0]  active_id_o,
    output logic                           busy_o,
    output logic [BUS_WIDTH-1:0]           unsync_bus_o,
    output logic                           bus_enable_o
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 be_q, be_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     id_q, id_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

`ifdef SYNC_ARB_RR_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    sync_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i    (req_i),
`ifdef SYNC_ARB_RR_EN
        .ptr_i    (ptr_q),
`endif
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        be_d    = be_q;
        gnt_d   = '0;
        id_d    = id_q;
        busy_d  = busy_q;
`ifdef SYNC_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                be_d = 1'b0;
                if (pick_any) begin
                    bus_d   = req_data_i[int'(pick_idx)*BUS_WIDTH +: BUS_WIDTH];
                    be_d    = 1'b1;
                    gnt_d   = pick_onehot;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
`ifdef SYNC_ARB_RR_EN
                    ptr_d   = pick_idx;
`endif
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    be_d    = 1'b0;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                be_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            be_q    <= 1'b0;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            be_q    <= be_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SYNC_ARB_RR_EN
    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt_o        = gnt_q;
    assign active_id_o  = id_q;
    assign busy_o       = busy_q;
    assign unsync_bus_o = bus_q;
    assign bus_enable_o = be_q;

endmodule

`default_nettype wire
